// File: rtl/video_rect_fill_arbiter.sv
// Solid-colour rectangle fill engine for the frame buffer. A fixed-priority arbiter gives the CPU
// the video write bus first; the engine only writes on cycles the CPU leaves the bus free.
module video_rect_fill_arbiter #(
  parameter int unsigned HMAX = 640,
  parameter int unsigned VMAX = 480,
  parameter int unsigned DW   = 9
) (
  input  logic          clk_sys,
  input  logic          reset_sys,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic          cpu_video_cs,
  input  logic          cpu_video_wr,
  input  logic [20:0]   cpu_video_addr,
  input  logic [31:0]   cpu_video_wr_data,
  output logic          video_cs,
  output logic          video_wr,
  output logic [20:0]   video_addr,
  output logic [31:0]   video_wr_data
);

  typedef enum logic [1:0] {StIdle, StSetup, StFill} state_e;

  state_e          state_q;
  logic [9:0]      x0_q, lx0_q;
  logic [8:0]      y0_q, ly0_q;
  logic [10:0]     w_q, lw_q, w_eff_q, col_q;
  logic [9:0]      h_q, lh_q, h_eff_q, row_q;
  logic [DW-1:0]   color_q, lcolor_q;
  logic [19:0]     base_q, pixcnt_q;
  logic            done_q, aborted_q;

  logic            reg_wr, ctrl_wr, start_req, abort_req, busy, eng_wr, degenerate;
  logic            last_col, last_row;
  logic [10:0]     avail_w;
  logic [9:0]      avail_h;
  logic [19:0]     fb_addr, setup_base;

  assign reg_wr    = cs & write;
  assign ctrl_wr   = reg_wr && (addr == 5'd5);
  assign start_req = ctrl_wr & wr_data[0] & ~wr_data[1];
  assign abort_req = ctrl_wr & wr_data[1];
  assign busy      = (state_q != StIdle);
  // An abort written this cycle already suppresses the engine's bus access.
  assign eng_wr    = (state_q == StFill) && !cpu_video_cs && !abort_req;

  assign degenerate = (32'(lx0_q) >= HMAX) || (32'(ly0_q) >= VMAX) ||
                      (lw_q == 11'd0) || (lh_q == 10'd0);
  assign avail_w    = 11'(HMAX) - 11'(lx0_q);
  assign avail_h    = 10'(VMAX) - 10'(ly0_q);
  // y*640 as y*512 + y*128, no multiplier.
  assign setup_base = (20'(ly0_q) << 9) + (20'(ly0_q) << 7) + 20'(lx0_q);
  assign fb_addr    = base_q + 20'(col_q);
  assign last_col   = (col_q == w_eff_q - 11'd1);
  assign last_row   = (row_q == h_eff_q - 10'd1);

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      state_q   <= StIdle;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      lx0_q     <= '0;
      ly0_q     <= '0;
      lw_q      <= '0;
      lh_q      <= '0;
      lcolor_q  <= '0;
      w_eff_q   <= '0;
      h_eff_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      pixcnt_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (addr)
          5'd0:    x0_q    <= wr_data[9:0];
          5'd1:    y0_q    <= wr_data[8:0];
          5'd2:    w_q     <= wr_data[10:0];
          5'd3:    h_q     <= wr_data[9:0];
          5'd4:    color_q <= wr_data[DW-1:0];
          default: ;
        endcase
      end
      unique case (state_q)
        StIdle: begin
          if (start_req) begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            pixcnt_q  <= '0;
            lx0_q     <= x0_q;
            ly0_q     <= y0_q;
            lw_q      <= w_q;
            lh_q      <= h_q;
            lcolor_q  <= color_q;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          if (degenerate) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            w_eff_q <= (lw_q < avail_w) ? lw_q : avail_w;
            h_eff_q <= (lh_q < avail_h) ? lh_q : avail_h;
            base_q  <= setup_base;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= StFill;
          end
        end
        StFill: begin
          if (eng_wr) begin
            pixcnt_q <= pixcnt_q + 20'd1;
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                row_q  <= row_q + 10'd1;
                base_q <= base_q + 20'(HMAX);
              end
            end else begin
              col_q <= col_q + 11'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (abort_req && busy) begin
        state_q   <= StIdle;
        aborted_q <= 1'b1;
        done_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data = 32'(x0_q);
      5'd1:    rd_data = 32'(y0_q);
      5'd2:    rd_data = 32'(w_q);
      5'd3:    rd_data = 32'(h_q);
      5'd4:    rd_data = 32'(color_q);
      5'd6:    rd_data = {29'd0, aborted_q, done_q, busy};
      5'd7:    rd_data = 32'(pixcnt_q);
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    if (eng_wr) begin
      video_cs      = 1'b1;
      video_wr      = 1'b1;
      video_addr    = {1'b1, fb_addr};
      video_wr_data = {{(32-DW){1'b0}}, lcolor_q};
    end else begin
      video_cs      = cpu_video_cs;
      video_wr      = cpu_video_wr;
      video_addr    = cpu_video_addr;
      video_wr_data = cpu_video_wr_data;
    end
  end

  logic unused_read;
  assign unused_read = read;

endmodule

// File: tb/tb_video_rect_fill_arbiter.sv
// Randomized bench for video_rect_fill_arbiter; expected pixel addresses come from a nested-loop
// raster model of the clipped rectangle.
module tb_video_rect_fill_arbiter;

  localparam int HMAX = 640;
  localparam int VMAX = 480;

  logic        clk_sys = 1'b0;
  logic        reset_sys;
  logic        cs, write, read;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        cpu_video_cs, cpu_video_wr;
  logic [20:0] cpu_video_addr;
  logic [31:0] cpu_video_wr_data;
  logic        video_cs, video_wr;
  logic [20:0] video_addr;
  logic [31:0] video_wr_data;

  int checks = 0;
  int errors = 0;

  video_rect_fill_arbiter dut (
    .clk_sys           (clk_sys),
    .reset_sys         (reset_sys),
    .cs                (cs),
    .write             (write),
    .read              (read),
    .addr              (addr),
    .wr_data           (wr_data),
    .rd_data           (rd_data),
    .cpu_video_cs      (cpu_video_cs),
    .cpu_video_wr      (cpu_video_wr),
    .cpu_video_addr    (cpu_video_addr),
    .cpu_video_wr_data (cpu_video_wr_data),
    .video_cs          (video_cs),
    .video_wr          (video_wr),
    .video_addr        (video_addr),
    .video_wr_data     (video_wr_data)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_idle();
    cpu_video_cs = 1'b0; cpu_video_wr = 1'b0; cpu_video_addr = '0; cpu_video_wr_data = '0;
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk_sys); #1;
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk_sys); #1;
    cs = 1'b0; write = 1'b0; addr = 5'd6; wr_data = '0;
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    addr = a; #1; d = rd_data; addr = 5'd6;
  endtask

  // Whole fill: program, start, observe every cycle until busy drops.
  task automatic run_fill(input int x0, input int y0, input int w, input int h,
                          input int color, input int cpu_pct);
    int exp_q[$];
    int we, he, idx, cycles, n;
    bit fin;
    logic [31:0] d;
    if (x0 < HMAX && y0 < VMAX && w > 0 && h > 0) begin
      we = (w < HMAX - x0) ? w : HMAX - x0;
      he = (h < VMAX - y0) ? h : VMAX - y0;
      for (int r = 0; r < he; r++)
        for (int c = 0; c < we; c++) exp_q.push_back(32'h100000 + (y0 + r) * HMAX + x0 + c);
    end
    n = exp_q.size();
    reg_wr(5'd0, x0); reg_wr(5'd1, y0); reg_wr(5'd2, w); reg_wr(5'd3, h);
    reg_wr(5'd4, color);
    reg_wr(5'd5, 32'd1);
    idx = 0; cycles = 0; fin = 0;
    while (!fin) begin
      if ($urandom_range(99) < cpu_pct) begin
        cpu_video_cs = 1'b1; cpu_video_wr = 1'($urandom);
        cpu_video_addr = 21'($urandom); cpu_video_wr_data = $urandom;
      end else cpu_idle();
      @(negedge clk_sys);
      cycles++;
      if (cpu_video_cs) begin
        check("cpu_verbatim", {video_cs, video_wr, video_addr, video_wr_data},
              {cpu_video_cs, cpu_video_wr, cpu_video_addr, cpu_video_wr_data});
      end else if (video_cs) begin
        if (idx < n) begin
          check("eng_addr", video_addr, exp_q[idx]);
          check("eng_data", {video_wr, video_wr_data}, {1'b1, 32'(color & 'h1FF)});
        end else check("extra_write", 1, 0);
        idx++;
      end
      if (rd_data[0] == 1'b0) fin = 1;
      if (cycles > 4 * n + 50) begin
        check("fill_timeout", 0, 1);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk_sys); #1;
      end
    end
    cpu_idle();
    check("write_count", idx, n);
    if (cpu_pct == 0) check("fill_latency", cycles, n + 2);
    read_reg(5'd6, d); check("status_done", d, 32'd2);
    read_reg(5'd7, d); check("pixcnt", d, n);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    reset_sys = 1'b1; cs = 0; write = 0; read = 0; addr = 5'd6; wr_data = '0;
    cpu_idle();
    repeat (3) @(posedge clk_sys);
    #1 reset_sys = 1'b0;
    @(negedge clk_sys);
    for (int i = 0; i < 9; i++) begin
      read_reg(5'(i), d); check("reset_reg", d, 0);
    end
    check("reset_video_cs", video_cs, 0);

    run_fill(10, 20, 4, 3, 'h1FF, 0);
    run_fill(638, 478, 5, 5, 'h0A5, 0);
    run_fill(5, 5, 0, 3, 'h011, 0);
    run_fill(640, 0, 4, 4, 'h022, 0);
    run_fill(10, 20, 16, 4, 'h155, 40);
    for (int t = 0; t < 10; t++) begin
      int x0, y0;
      x0 = ($urandom_range(1) == 1) ? HMAX + 2 - $urandom_range(12) : $urandom_range(HMAX - 1);
      y0 = ($urandom_range(1) == 1) ? VMAX + 2 - $urandom_range(10) : $urandom_range(VMAX - 1);
      run_fill(x0, y0, $urandom_range(12), $urandom_range(6), $urandom_range(511),
               ($urandom_range(1) == 1) ? 30 : 0);
    end

    // Abort after 5 writes of an 8x8 fill, then restart to completion.
    reg_wr(5'd0, 0); reg_wr(5'd1, 0); reg_wr(5'd2, 8); reg_wr(5'd3, 8);
    reg_wr(5'd5, 32'd1);
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk_sys);
      if (video_cs) begin
        check("abort_pre_addr", video_addr, 21'h100000 + 21'(n));
        n++;
      end
      @(posedge clk_sys); #1;
    end
    check("abort_pre_count", n, 5);
    cs = 1'b1; write = 1'b1; addr = 5'd5; wr_data = 32'd2;
    @(negedge clk_sys);
    check("abort_cycle_nowrite", video_cs, 0);
    @(posedge clk_sys); #1;
    cs = 1'b0; write = 1'b0; addr = 5'd6; wr_data = '0;
    n = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (video_cs) n++;
    end
    check("abort_post_writes", n, 0);
    read_reg(5'd6, d); check("abort_status", d, 32'd4);
    read_reg(5'd7, d); check("abort_pixcnt", d, 32'd5);
    run_fill(0, 0, 8, 8, 'h0F0, 0);

    // Reset mid-fill.
    reg_wr(5'd5, 32'd1);
    repeat (4) @(posedge clk_sys);
    #1 reset_sys = 1'b1;
    @(posedge clk_sys); #1;
    reset_sys = 1'b0;
    cpu_video_cs = 1'b1; cpu_video_wr = 1'b1; cpu_video_addr = 21'h0ABCDE;
    cpu_video_wr_data = 32'hDEADBEEF;
    @(negedge clk_sys);
    check("rst_cpu_verbatim", {video_cs, video_wr, video_addr, video_wr_data},
          {1'b1, 1'b1, 21'h0ABCDE, 32'hDEADBEEF});
    @(posedge clk_sys); #1;
    cpu_idle();
    n = 0;
    repeat (5) begin
      @(negedge clk_sys);
      if (video_cs) n++;
    end
    check("rst_no_writes", n, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(5'(i), d); check("rst_reg", d, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
